sa_io_skew_ring: RTL and testbench
==================================

# sa_io_skew_ring

Parametrised input/output register ring for the systolic mesh core. It replaces the fixed single-stage I/O flop ring used for timing characterisation. Per-row pipeline depth is configurable, and the block adds optional input skew and output deskew so callers can drive and sample all rows aligned. It also adds valid-gated data capture, an in-flight busy flag and a beat counter. The block sits between the harness and the mesh, and all traffic to and from the mesh passes through it.

## Interface
Parameters:
- ROWS, 8, number of mesh rows
- A_W, 8, width of a, b-in and d per row
- C_W, 19, width of out_c and out_b per row
- SHIFT_W, 6, control shift width
- IN_STAGES, 1, base input register depth, >= 1
- OUT_STAGES, 1, base output register depth, >= 1
- SKEW_EN, 1, 1 = row skew/deskew enabled, 0 = uniform depth

Ports (row r of a flattened bus occupies bits [r*W +: W]):
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- in_a, in_b, in_d  in  ROWS*A_W  harness operands
- in_propagate  in  ROWS  control propagate
- in_shift  in  ROWS*SHIFT_W  control shift
- in_valid  in  ROWS  per-row valid
- mesh_a, mesh_b, mesh_d  out  ROWS*A_W  operands to mesh
- mesh_propagate  out  ROWS
- mesh_shift  out  ROWS*SHIFT_W
- mesh_valid  out  ROWS
- mesh_out_c, mesh_out_b  in  ROWS*C_W  mesh results
- mesh_out_valid  in  1  mesh output valid, aligned with row 0
- out_c, out_b  out  ROWS*C_W  deskewed results
- out_valid  out  1  deskewed valid
- busy  out  1  any valid bit in flight in either ring
- cnt_clr  in  1  clears beat_cnt
- beat_cnt  out  32  saturating count of out_valid beats

## Operation
- Input ring, row r: depth DI(r) = IN_STAGES + (SKEW_EN ? r : 0).
- The valid bit shifts through every stage each cycle.
- a, b, d, propagate and shift at stage k load from stage k-1 only when the stage k-1 valid is 1. Otherwise they hold their value (power gating).
- Output ring, row r: depth DO(r) = OUT_STAGES + (SKEW_EN ? ROWS-1-r : 0).
- c and b capture unconditionally every cycle.
- mesh_out_valid is delayed by OUT_STAGES + (SKEW_EN ? ROWS-1 : 0) and driven on out_valid.
- busy = OR of every valid flop in the input ring and the output valid chain, registered.
- beat_cnt increments by 1 on each cycle where out_valid=1 and saturates at 0xFFFF_FFFF.
- cnt_clr=1 forces beat_cnt to 0 on the next edge. If cnt_clr and out_valid are both 1 in the same cycle, cnt_clr wins and beat_cnt goes to 0.
- Reset: on a CLK edge with RST=1, every flop clears to 0. Every output reads 0 after that edge, including mesh_*, out_*, busy and beat_cnt.
- Reset mid-operation: all in-flight beats are discarded. No out_valid is produced for beats accepted before reset.
- No backpressure. The block never stalls or drops a beat. Throughput is 1 beat/row/cycle.

## Timing
- in_* of row r sampled at edge t appears on mesh_* row r after edge t+DI(r)-1, i.e. visible in cycle t+DI(r).
- Defaults with SKEW_EN=1: row 0 latency 1, row 7 latency 8.
- mesh_out_c row r sampled at edge t appears on out_c row r in cycle t+DO(r).
- A mesh wavefront where row r is valid at cycle t0+r leaves on all rows together at cycle t0+OUT_STAGES+ROWS-1.
- Round trip for aligned harness rows is IN_STAGES + OUT_STAGES + (ROWS-1) + mesh latency. The skew terms cancel across rows.
- busy rises the cycle after the first valid enters stage 1. It falls one cycle after the last valid flop clears.
- beat_cnt updates the cycle after out_valid.
- With SKEW_EN=0, every row has depth IN_STAGES in and OUT_STAGES out. This is identical to the legacy ring when both are 1.

## Test plan
- Reset: drive all inputs to all-ones and hold RST for 2 cycles → every output 0, busy=0, beat_cnt=0.
- Input skew, defaults: at cycle 0 in_valid=0xFF and row r in_a=r+1, then valid=0 → mesh_valid[r]=1 only in cycle 1+r, and mesh_a row r = r+1 from then on (held).
- Valid gating: in_valid=0 while in_a toggles 0x00↔0xFF for 10 cycles → mesh_a unchanged and mesh_valid=0 throughout.
- Output deskew: mesh_out_c row r = 0x100+r pulsed in cycle r, mesh_out_valid=1 in cycle 0 → out_c all rows equal 0x100+r simultaneously in cycle 8, out_valid=1 in cycle 8 only.
- Counter: preload via 2^32-2 valid beats (force), then 3 beats → beat_cnt saturates at 0xFFFF_FFFF. Then cnt_clr together with out_valid → beat_cnt=0.
- Mid-flight reset: launch valid on all rows, then RST=1 in cycle 3 → busy=0 from cycle 4, and no mesh_valid or out_valid afterwards.

Source files
------------

// File: rtl/sa_io_skew_ring.sv
`default_nettype none
// ============================================================================
// Module   : sa_io_skew_ring
// Purpose  : Parametrised input/output register ring between the harness and
//            the systolic mesh. Each row has a configurable pipeline depth.
//            With SKEW_EN=1 the input ring skews row r by r extra stages and
//            the output ring deskews row r by ROWS-1-r extra stages, so the
//            harness drives and samples all rows aligned. Operand stages are
//            valid-gated (they hold when no valid beat arrives). There is
//            also a registered busy flag and a saturating beat counter.
//
// Ports    : CLK, RST            clock, synchronous active-high reset
//            in_a/b/d            harness operands, ROWS*A_W
//            in_propagate        per-row propagate control
//            in_shift            per-row shift control, ROWS*SHIFT_W
//            in_valid            per-row valid
//            mesh_a/b/d, mesh_propagate, mesh_shift, mesh_valid
//                                skewed operands and controls to the mesh
//            mesh_out_c/b        mesh results, ROWS*C_W
//            mesh_out_valid      mesh result valid, aligned with row 0
//            out_c/b, out_valid  deskewed results and valid
//            busy                any valid bit in flight in either ring
//            cnt_clr             clears beat_cnt
//            beat_cnt            saturating count of out_valid beats
//
// Revision : 1.0 - initial release
// ============================================================================
module sa_io_skew_ring #(
  parameter int ROWS       = 8,
  parameter int A_W        = 8,
  parameter int C_W        = 19,
  parameter int SHIFT_W    = 6,
  parameter int IN_STAGES  = 1,
  parameter int OUT_STAGES = 1,
  parameter int SKEW_EN    = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [ROWS*A_W-1:0]       in_a,
  input  logic [ROWS*A_W-1:0]       in_b,
  input  logic [ROWS*A_W-1:0]       in_d,
  input  logic [ROWS-1:0]           in_propagate,
  input  logic [ROWS*SHIFT_W-1:0]   in_shift,
  input  logic [ROWS-1:0]           in_valid,
  output logic [ROWS*A_W-1:0]       mesh_a,
  output logic [ROWS*A_W-1:0]       mesh_b,
  output logic [ROWS*A_W-1:0]       mesh_d,
  output logic [ROWS-1:0]           mesh_propagate,
  output logic [ROWS*SHIFT_W-1:0]   mesh_shift,
  output logic [ROWS-1:0]           mesh_valid,
  input  logic [ROWS*C_W-1:0]       mesh_out_c,
  input  logic [ROWS*C_W-1:0]       mesh_out_b,
  input  logic                      mesh_out_valid,
  output logic [ROWS*C_W-1:0]       out_c,
  output logic [ROWS*C_W-1:0]       out_b,
  output logic                      out_valid,
  output logic                      busy,
  input  logic                      cnt_clr,
  output logic [31:0]               beat_cnt
);

  // Operand payload carried through one input stage: a, b, d, propagate, shift.
  localparam int c_PW = 3*A_W + 1 + SHIFT_W;

  // The output valid travels with row 0, which has the deepest output ring.
  localparam int c_VD = OUT_STAGES + ((SKEW_EN != 0) ? (ROWS - 1) : 0);

  localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

  logic [ROWS-1:0]  w_in_vld_any;   // per-row OR of input-ring valid flops
  logic [c_VD-1:0]  r_ov;           // output valid delay chain
  logic             r_busy;
  logic [31:0]      r_beat_cnt;

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int c_DI = IN_STAGES  + ((SKEW_EN != 0) ? r              : 0);
      localparam int c_DO = OUT_STAGES + ((SKEW_EN != 0) ? (ROWS - 1 - r) : 0);

      logic [c_PW-1:0] w_in_pay;
      logic [c_DI-1:0] r_vld;
      logic [c_PW-1:0] r_pay [c_DI];
      logic [C_W-1:0]  r_c   [c_DO];
      logic [C_W-1:0]  r_b   [c_DO];

      assign w_in_pay = {in_a[r*A_W +: A_W],
                         in_b[r*A_W +: A_W],
                         in_d[r*A_W +: A_W],
                         in_propagate[r],
                         in_shift[r*SHIFT_W +: SHIFT_W]};

      // Input ring: valid always shifts; payload only moves behind a valid
      // bit so idle stages do not toggle.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_vld <= '0;
          for (int k = 0; k < c_DI; k++) begin
            r_pay[k] <= '0;
          end
        end else begin
          r_vld[0] <= in_valid[r];
          if (in_valid[r]) begin
            r_pay[0] <= w_in_pay;
          end
          for (int k = 1; k < c_DI; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
              r_pay[k] <= r_pay[k-1];
            end
          end
        end
      end

      assign {mesh_a[r*A_W +: A_W],
              mesh_b[r*A_W +: A_W],
              mesh_d[r*A_W +: A_W],
              mesh_propagate[r],
              mesh_shift[r*SHIFT_W +: SHIFT_W]} = r_pay[c_DI-1];
      assign mesh_valid[r]   = r_vld[c_DI-1];
      assign w_in_vld_any[r] = |r_vld;

      // Output ring: results are captured every cycle; the mesh drives
      // row r one cycle later than row r-1, so shallower rows for higher r
      // bring every row out together.
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int k = 0; k < c_DO; k++) begin
            r_c[k] <= '0;
            r_b[k] <= '0;
          end
        end else begin
          r_c[0] <= mesh_out_c[r*C_W +: C_W];
          r_b[0] <= mesh_out_b[r*C_W +: C_W];
          for (int k = 1; k < c_DO; k++) begin
            r_c[k] <= r_c[k-1];
            r_b[k] <= r_b[k-1];
          end
        end
      end

      assign out_c[r*C_W +: C_W] = r_c[c_DO-1];
      assign out_b[r*C_W +: C_W] = r_b[c_DO-1];
    end
  endgenerate

  // Output valid delay chain, matched to row 0's output depth.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ov <= '0;
    end else begin
      r_ov[0] <= mesh_out_valid;
      for (int k = 1; k < c_VD; k++) begin
        r_ov[k] <= r_ov[k-1];
      end
    end
  end

  assign out_valid = r_ov[c_VD-1];

  // Busy is a registered OR of every valid flop, so it lags the flops by one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (|w_in_vld_any) | (|r_ov);
    end
  end

  assign busy = r_busy;

  // Beat counter: clear has priority over counting; counting saturates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_beat_cnt <= '0;
    end else if (cnt_clr) begin
      r_beat_cnt <= '0;
    end else if (out_valid && (r_beat_cnt != c_CNT_MAX)) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sa_io_skew_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_io_skew_ring
// Purpose  : Self-checking bench for sa_io_skew_ring. Every applied input is
//            logged per clock edge; expected outputs are derived from that
//            log with the block's latency rules (row depths, last valid beat,
//            last reset edge), then compared after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_io_skew_ring;

  localparam int ROWS = 8;
  localparam int A_W  = 8;
  localparam int C_W  = 19;
  localparam int SW   = 6;
  localparam int IS   = 1;
  localparam int OS   = 1;
  localparam int SK   = 1;
  localparam int VD   = OS + ((SK != 0) ? ROWS - 1 : 0);
  localparam int NMAX = 1024;

  logic                  CLK;
  logic                  RST;
  logic [ROWS*A_W-1:0]   in_a, in_b, in_d;
  logic [ROWS-1:0]       in_propagate;
  logic [ROWS*SW-1:0]    in_shift;
  logic [ROWS-1:0]       in_valid;
  logic [ROWS*A_W-1:0]   mesh_a, mesh_b, mesh_d;
  logic [ROWS-1:0]       mesh_propagate;
  logic [ROWS*SW-1:0]    mesh_shift;
  logic [ROWS-1:0]       mesh_valid;
  logic [ROWS*C_W-1:0]   mesh_out_c, mesh_out_b;
  logic                  mesh_out_valid;
  logic [ROWS*C_W-1:0]   out_c, out_b;
  logic                  out_valid;
  logic                  busy;
  logic                  cnt_clr;
  logic [31:0]           beat_cnt;

  sa_io_skew_ring #(
    .ROWS(ROWS), .A_W(A_W), .C_W(C_W), .SHIFT_W(SW),
    .IN_STAGES(IS), .OUT_STAGES(OS), .SKEW_EN(SK)
  ) dut (
    .CLK(CLK), .RST(RST),
    .in_a(in_a), .in_b(in_b), .in_d(in_d),
    .in_propagate(in_propagate), .in_shift(in_shift), .in_valid(in_valid),
    .mesh_a(mesh_a), .mesh_b(mesh_b), .mesh_d(mesh_d),
    .mesh_propagate(mesh_propagate), .mesh_shift(mesh_shift),
    .mesh_valid(mesh_valid),
    .mesh_out_c(mesh_out_c), .mesh_out_b(mesh_out_b),
    .mesh_out_valid(mesh_out_valid),
    .out_c(out_c), .out_b(out_b), .out_valid(out_valid),
    .busy(busy), .cnt_clr(cnt_clr), .beat_cnt(beat_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Input log, one entry per clock edge.
  logic [ROWS-1:0]     h_iv  [NMAX];
  logic [ROWS*A_W-1:0] h_a   [NMAX];
  logic [ROWS*A_W-1:0] h_b   [NMAX];
  logic [ROWS*A_W-1:0] h_d   [NMAX];
  logic [ROWS-1:0]     h_p   [NMAX];
  logic [ROWS*SW-1:0]  h_s   [NMAX];
  logic [ROWS*C_W-1:0] h_mc  [NMAX];
  logic [ROWS*C_W-1:0] h_mb  [NMAX];
  logic                h_mv  [NMAX];
  logic                h_rst [NMAX];
  logic                h_clr [NMAX];

  int          e;          // number of edges applied so far
  int          last_rst;   // most recent edge with RST=1
  logic        m_prev_ov;  // expected out_valid after the previous edge
  logic [31:0] m_cnt;      // expected beat_cnt
  int          n_checks;
  int          n_fail;

  function automatic int di(input int r);
    return IS + ((SK != 0) ? r : 0);
  endfunction

  function automatic int dout(input int r);
    return OS + ((SK != 0) ? (ROWS - 1 - r) : 0);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected outputs after edge n, from the log.
  task automatic check_edge(input int n);
    logic [ROWS-1:0]     ev, ep;
    logic [ROWS*A_W-1:0] ea, eb, ed;
    logic [ROWS*SW-1:0]  es;
    logic [ROWS*C_W-1:0] ec, ebo;
    logic                eov, ebusy;
    int                  m;
    logic                found;
    if (h_rst[n]) last_rst = n;
    ev = '0; ep = '0; ea = '0; eb = '0; ed = '0; es = '0; ec = '0; ebo = '0;
    for (int r = 0; r < ROWS; r++) begin
      m = n - di(r) + 1;
      if (m > last_rst && m >= 0) ev[r] = h_iv[m][r];
      // Operands at the mesh are those of the newest valid beat that has
      // had time to arrive since the last reset.
      found = 1'b0;
      for (int j = m; j > last_rst && j >= 0; j--) begin
        if (!found && h_iv[j][r]) begin
          found = 1'b1;
          ea[r*A_W +: A_W] = h_a[j][r*A_W +: A_W];
          eb[r*A_W +: A_W] = h_b[j][r*A_W +: A_W];
          ed[r*A_W +: A_W] = h_d[j][r*A_W +: A_W];
          ep[r]            = h_p[j][r];
          es[r*SW +: SW]   = h_s[j][r*SW +: SW];
        end
      end
      m = n - dout(r) + 1;
      if (m > last_rst && m >= 0) begin
        ec[r*C_W +: C_W]  = h_mc[m][r*C_W +: C_W];
        ebo[r*C_W +: C_W] = h_mb[m][r*C_W +: C_W];
      end
    end
    m = n - VD + 1;
    eov = (m > last_rst && m >= 0) ? h_mv[m] : 1'b0;
    // Busy reflects whether any valid bit was in flight after edge n-1.
    ebusy = 1'b0;
    if (!h_rst[n]) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < di(r); k++) begin
          m = n - 1 - k;
          if (m > last_rst && m >= 0 && h_iv[m][r]) ebusy = 1'b1;
        end
      end
      for (int k = 0; k < VD; k++) begin
        m = n - 1 - k;
        if (m > last_rst && m >= 0 && h_mv[m]) ebusy = 1'b1;
      end
    end
    if (h_rst[n] || h_clr[n]) m_cnt = '0;
    else if (m_prev_ov && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    m_prev_ov = eov;

    chk("mesh_valid",     256'(mesh_valid),     256'(ev));
    chk("mesh_a",         256'(mesh_a),         256'(ea));
    chk("mesh_b",         256'(mesh_b),         256'(eb));
    chk("mesh_d",         256'(mesh_d),         256'(ed));
    chk("mesh_propagate", 256'(mesh_propagate), 256'(ep));
    chk("mesh_shift",     256'(mesh_shift),     256'(es));
    chk("out_c",          256'(out_c),          256'(ec));
    chk("out_b",          256'(out_b),          256'(ebo));
    chk("out_valid",      256'(out_valid),      256'(eov));
    chk("busy",           256'(busy),           256'(ebusy));
    chk("beat_cnt",       256'(beat_cnt),       256'(m_cnt));
  endtask

  // Log the inputs, apply one edge, then check away from the edge.
  task automatic tick();
    if (e >= NMAX) begin
      $display("FAIL edge_budget observed=%0d required<%0d", e, NMAX);
      $fatal(1, "edge log overflow");
    end
    h_iv[e] = in_valid; h_a[e] = in_a; h_b[e] = in_b; h_d[e] = in_d;
    h_p[e] = in_propagate; h_s[e] = in_shift;
    h_mc[e] = mesh_out_c; h_mb[e] = mesh_out_b; h_mv[e] = mesh_out_valid;
    h_rst[e] = RST; h_clr[e] = cnt_clr;
    @(posedge CLK);
    #1;
    check_edge(e);
    e++;
  endtask

  task automatic idle_inputs();
    in_a = '0; in_b = '0; in_d = '0; in_propagate = '0; in_shift = '0;
    in_valid = '0; mesh_out_c = '0; mesh_out_b = '0; mesh_out_valid = 1'b0;
    cnt_clr = 1'b0; RST = 1'b0;
  endtask

  logic [ROWS*A_W-1:0] skew_a;
  logic [ROWS*C_W-1:0] deskew_c;

  initial begin
    e = 0; last_rst = -1; m_prev_ov = 1'b0; m_cnt = '0;
    n_checks = 0; n_fail = 0;

    // Reset with every input at all-ones.
    RST = 1'b1; in_a = '1; in_b = '1; in_d = '1; in_propagate = '1;
    in_shift = '1; in_valid = '1; mesh_out_c = '1; mesh_out_b = '1;
    mesh_out_valid = 1'b1; cnt_clr = 1'b1;
    #2;
    tick(); tick();
    chk("reset_mesh_valid", 256'(mesh_valid), 256'(0));
    chk("reset_out_c",      256'(out_c),      256'(0));
    chk("reset_busy",       256'(busy),       256'(0));
    chk("reset_beat_cnt",   256'(beat_cnt),   256'(0));
    idle_inputs();
    tick(); tick();

    // Input skew: one aligned beat, row r carries r+1.
    for (int r = 0; r < ROWS; r++) skew_a[r*A_W +: A_W] = 8'(r + 1);
    in_valid = '1; in_a = skew_a;
    tick();
    chk("skew_valid_0", 256'(mesh_valid), 256'(8'h01));
    in_valid = '0; in_a = '0;
    for (int j = 1; j < 10; j++) begin
      tick();
      chk("skew_valid_j", 256'(mesh_valid), 256'((j < ROWS) ? (8'(1) << j) : 8'h00));
    end
    chk("skew_held_a", 256'(mesh_a), 256'(skew_a));

    // Valid gating: toggling operands without valid must not move them.
    for (int j = 0; j < 10; j++) begin
      in_a = (j % 2 == 0) ? '0 : '1;
      tick();
      chk("gate_a",     256'(mesh_a),     256'(skew_a));
      chk("gate_valid", 256'(mesh_valid), 256'(0));
    end
    in_a = '0;

    // Output deskew: row r result arrives at relative cycle r.
    for (int r = 0; r < ROWS; r++) deskew_c[r*C_W +: C_W] = 19'(32'h100 + r);
    for (int j = 0; j < 10; j++) begin
      mesh_out_c = '0;
      if (j < ROWS) mesh_out_c[j*C_W +: C_W] = 19'(32'h100 + j);
      mesh_out_valid = (j == 0);
      tick();
      chk("deskew_valid", 256'(out_valid), 256'(j == ROWS - 1));
      if (j == ROWS - 1) chk("deskew_c", 256'(out_c), 256'(deskew_c));
    end
    idle_inputs();
    for (int j = 0; j < 4; j++) tick();

    // Counter saturation from a preloaded value, then clear beating a beat.
    force dut.r_beat_cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.r_beat_cnt;
    for (int k = 0; k <= 10; k++) begin
      mesh_out_valid = (k < 4);
      tick();
    end
    chk("cnt_saturated", 256'(beat_cnt),  256'(32'hFFFF_FFFF));
    chk("cnt_clr_ov",    256'(out_valid), 256'(1));
    cnt_clr = 1'b1;
    tick();
    chk("cnt_cleared",   256'(beat_cnt),  256'(0));
    cnt_clr = 1'b0;
    for (int j = 0; j < 4; j++) tick();

    // Mid-flight reset discards everything in flight.
    in_valid = '1; mesh_out_valid = 1'b1; in_a = 64'h1122334455667788;
    for (int j = 0; j < 3; j++) tick();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("mid_rst_busy",       256'(busy),       256'(0));
      chk("mid_rst_mesh_valid", 256'(mesh_valid), 256'(0));
      chk("mid_rst_out_valid",  256'(out_valid),  256'(0));
      tick();
    end

    // Random traffic against the log-based model.
    for (int j = 0; j < 400; j++) begin
      in_valid       = 8'($urandom);
      in_a           = 64'({$urandom(), $urandom()});
      in_b           = 64'({$urandom(), $urandom()});
      in_d           = 64'({$urandom(), $urandom()});
      in_propagate   = 8'($urandom);
      in_shift       = 48'({$urandom(), $urandom()});
      mesh_out_c     = 152'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      mesh_out_b     = 152'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      mesh_out_valid = 1'($urandom);
      cnt_clr        = ($urandom_range(0, 15) == 0);
      RST            = ($urandom_range(0, 79) == 0);
      tick();
    end
    idle_inputs();
    for (int j = 0; j < 12; j++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
